// File: rtl/clk_div_multi_if.sv
// Control/status bundle for the multi-channel clock divider.
interface clk_div_multi_if #(
  parameter int NUM_CH    = 2,
  parameter int CNT_WIDTH = 26
);
  logic [NUM_CH-1:0]    en;
  logic [NUM_CH-1:0]    div_load;
  logic [CNT_WIDTH-1:0] div_in;
  logic [NUM_CH-1:0]    div_busy;
  logic [NUM_CH-1:0]    clk_out;
  logic [NUM_CH-1:0]    tick;
  logic [1:0]           scan_ctl;

  modport master (
    output en, div_load, div_in,
    input  div_busy, clk_out, tick, scan_ctl
  );

  modport slave (
    input  en, div_load, div_in,
    output div_busy, clk_out, tick, scan_ctl
  );
endinterface

// File: rtl/clk_div_multi.sv
// NUM_CH programmable 50%-duty clock dividers with tick strobes,
// plus a free-running scan counter for display multiplexing.
module clk_div_multi #(
  parameter int NUM_CH     = 2,
  parameter int CNT_WIDTH  = 26,
  parameter int RST_HALF   = 49999999,
  parameter int SCAN_WIDTH = 20
) (
  input logic           clk,
  input logic           rst,
  clk_div_multi_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] HALF_RST =
    CNT_WIDTH'(RST_HALF);

  logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] half_q, half_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] busy_q, busy_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] stall, term;
  logic [SCAN_WIDTH-1:0] scan_q, scan_d;

  always_comb begin
    cnt_d  = cnt_q;
    half_d = half_q;
    pend_d = pend_q;
    busy_d = busy_q;
    clk_d  = clk_q;
    tick_d = '0;
    stall  = '0;
    term   = '0;
    scan_d = scan_q + 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      stall[i] = !bus.en[i] || (half_q[i] == '0);
      term[i]  = !stall[i] && (cnt_q[i] == half_q[i]);
      if (half_q[i] == '0) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
      end else if (bus.en[i]) begin
        if (term[i]) begin
          cnt_d[i]  = '0;
          clk_d[i]  = ~clk_q[i];
          tick_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      // New half-periods only land on a toggle or while stalled,
      // so cnt can never be left above half.
      if (bus.div_load[i]) begin
        if (term[i]) begin
          half_d[i] = bus.div_in;
          busy_d[i] = 1'b0;
        end else if (stall[i]) begin
          half_d[i] = bus.div_in;
          busy_d[i] = 1'b0;
          cnt_d[i]  = '0;
        end else begin
          pend_d[i] = bus.div_in;
          busy_d[i] = 1'b1;
        end
      end else if (busy_q[i]) begin
        if (term[i]) begin
          half_d[i] = pend_q[i];
          busy_d[i] = 1'b0;
        end else if (stall[i]) begin
          half_d[i] = pend_q[i];
          busy_d[i] = 1'b0;
          cnt_d[i]  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      half_q <= {NUM_CH{HALF_RST}};
      pend_q <= '0;
      busy_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
      scan_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      scan_q <= scan_d;
    end
  end

  assign bus.div_busy = busy_q;
  assign bus.clk_out  = clk_q;
  assign bus.tick     = tick_q;
  assign bus.scan_ctl = scan_q[SCAN_WIDTH-1 -: 2];
endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised, multi-channel successor to the team's fixed 1 Hz divider.
- NUM_CH independent channels, each producing a 50%-duty divided clock and a one-cycle tick strobe.
- Each channel has a runtime-programmable half-period, loaded without glitches at the channel's next toggle boundary, and a per-channel enable.
- A shared free-running counter supplies the 2-bit scan-control output for 7-segment/LED multiplexing.

Parameters:
NUM_CH, 2, number of divider channels
CNT_WIDTH, 26, width of each channel counter and half-period value
RST_HALF, 49999999, half-period loaded into every channel at reset (1 Hz from 100 MHz)
SCAN_WIDTH, 20, width of scan counter; scan_ctl = its two MSBs

Ports:
clk  input  1  global clock; all logic on posedge
rst  input  1  asynchronous, active-high reset
en  input  NUM_CH  per-channel run enable
div_load  input  NUM_CH  per-channel one-cycle strobe: capture div_in as new half-period
div_in  input  CNT_WIDTH  shared half-period value (output period = 2*(div_in+1) clk cycles)
div_busy  output  NUM_CH  1 = a loaded value is pending, not yet applied
clk_out  output  NUM_CH  divided clock per channel
tick  output  NUM_CH  one-cycle pulse on every clk_out toggle
scan_ctl  output  2  scan select, scan_cnt[SCAN_WIDTH-1:SCAN_WIDTH-2]

Behaviour:
- Reset (rst high, async, no clock edge needed):
  - cnt=0, half=RST_HALF, pending=0.
  - div_busy=0, clk_out=0, tick=0, scan counter=0.
- Reset asserted mid-operation discards any pending load.
- Per channel, en=1, half>0:
  - cnt<half: cnt<=cnt+1, tick<=0.
  - cnt==half: cnt<=0, clk_out<=~clk_out, tick<=1 (registered; tick high exactly the cycle after the toggle edge, aligned with new clk_out).
  - First toggle occurs on the (half+1)th rising edge with en high after reset.
- en=0: cnt and clk_out hold; tick<=0. Re-enable resumes from the held count (no restart).
- half==0: channel idle. clk_out<=0, tick<=0, cnt<=0, regardless of en.
- div_load[i]=1: pending<=div_in, div_busy[i]<=1.
- Pending is applied (half<=pending, busy<=0):
  - At the next terminal-count edge (same edge as toggle; the new half governs the following half-period), or
  - Immediately on the next edge if the channel is stalled (en[i]=0 or half==0); cnt<=0, clk_out unchanged.
- Simultaneous events:
  - div_load while busy: pending overwritten, busy stays 1.
  - div_load on the terminal-count edge: div_in is applied directly at that edge, busy stays 0.
  - div_load with en=0 on the same edge: immediate apply, cnt<=0.
- Wrap-around: cnt never exceeds half. Loading a value smaller than the current cnt is safe because application occurs only at cnt==half or while stalled.
- Scan counter:
  - Free-running (ignores en), wraps 2^SCAN_WIDTH-1 -> 0.
  - scan_ctl is a direct register slice; no combinational path from inputs.
- All outputs registered.

Test Plan:
- CNT_WIDTH=8, RST_HALF=3, NUM_CH=2; release rst, en=2'b11 -> each clk_out toggles on edges 4,8,12…, period 8; tick=1 for exactly one cycle after each toggle; channels in phase.
- Ch0 running half=3; mid-period (cnt=1) div_load[0]=1, div_in=1 -> div_busy[0]=1 until ch0's next toggle, then 0. Subsequent ch0 period 4, ch1 unaffected (period 8).
- div_load[1]=1, div_in=0 -> after application clk_out[1]=0 and tick[1]=0 permanently. Later div_in=2 load applies on the next edge; toggles resume every 3 cycles.
- Ch0 at cnt=2, en[0]=0 for 5 cycles -> clk_out[0] and tick[0] frozen/0. Re-enable -> toggle after exactly 2 more edges.
- div_load[0] twice (div_in=5, then 6) before terminal count -> half becomes 6 (period 14), busy clears once. Load on the terminal-count edge -> applied at that edge, busy never set.
- rst pulsed asynchronously between edges mid-count -> all outputs 0 immediately. After release, half=3 restored and pending cleared. With SCAN_WIDTH=4, scan_ctl steps 0,1,2,3,0 every 4 cycles.
